// File: rtl/ffctl_seq_if.sv
// ffctl_seq_if: command handshake and flop-bank control bundle for ffctl_seq.
// The master side issues commands and observes the strobes. The slave side
// (the sequencer) accepts commands and drives the strobes.
interface ffctl_seq_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] ff_d;
  logic             ff_en;
  logic             ff_pre;
  logic             ff_clr;
  logic             done;
  logic [WIDTH-1:0] q_model;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, ff_d, ff_en, ff_pre, ff_clr, done, q_model
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, ff_d, ff_en, ff_pre, ff_clr, done, q_model
  );
endinterface

// File: rtl/ffctl_seq.sv
// ffctl_seq: sequencer that turns LOAD/PRESET/CLEAR/NOP commands into
// one-cycle strobes for a downstream flop bank. After each strobe it waits
// SETTLE idle cycles and then pulses done. It also keeps a model of the
// bank contents.
// All outputs are registered. The output values are computed from the next
// state, so each output changes on the same edge as the state.
// Optional build macro FFCTL_CNT_EN adds an 8-bit cmd_count output. It
// counts done pulses and wraps from 255 to 0.
module ffctl_seq #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       clr,
  ffctl_seq_if.slave bus
`ifdef FFCTL_CNT_EN
  ,
  output logic [7:0] cmd_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_PRESET = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  // Counter start value. With SETTLE=0 the counter is never used.
  localparam logic [3:0] SETTLE_M1 = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [3:0]       r_cnt;
  logic             r_cmd_ready;
  logic [WIDTH-1:0] r_ff_d;
  logic             r_ff_en;
  logic             r_ff_pre;
  logic             r_ff_clr;
  logic             r_done;
  logic [WIDTH-1:0] r_q_model;

  state_t           w_state_nxt;
  logic [1:0]       w_op_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic [3:0]       w_cnt_nxt;
  logic             w_accept;
  logic             w_drive_nxt;

  // r_cmd_ready is high only while the state is IDLE. It stays low on the
  // first cycle after reset, so a command cannot be accepted then.
  assign w_accept    = r_cmd_ready & bus.cmd_valid;
  assign w_drive_nxt = (w_state_nxt == ST_DRIVE);

  // Next-state logic: capture the command, then step DRIVE -> SETTLE -> DONE.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_op_nxt    = bus.cmd_op;
          w_data_nxt  = bus.cmd_data;
          w_state_nxt = (bus.cmd_op == OP_NOP) ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (SETTLE == 0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = SETTLE_M1;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and the captured command context.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!clr) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
      r_data  <= '0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered outputs: strobes, handshake ready, done, and the bank model.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_cmd_ready <= 1'b0;
      r_ff_d      <= '0;
      r_ff_en     <= 1'b0;
      r_ff_pre    <= 1'b0;
      r_ff_clr    <= 1'b0;
      r_done      <= 1'b0;
      r_q_model   <= '0;
    end else begin
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_ff_en     <= w_drive_nxt && (w_op_nxt == OP_LOAD);
      r_ff_pre    <= w_drive_nxt && (w_op_nxt == OP_PRESET);
      r_ff_clr    <= w_drive_nxt && (w_op_nxt == OP_CLEAR);
      r_ff_d      <= (w_drive_nxt && (w_op_nxt == OP_LOAD)) ? w_data_nxt : '0;
      r_done      <= (w_state_nxt == ST_DONE);
      // The bank captures the strobe at the end of the DRIVE cycle.
      if (r_state == ST_DRIVE) begin
        case (r_op)
          OP_LOAD:   r_q_model <= r_data;
          OP_PRESET: r_q_model <= '1;
          OP_CLEAR:  r_q_model <= '0;
          default:   r_q_model <= r_q_model;
        endcase
      end
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.ff_d      = r_ff_d;
  assign bus.ff_en     = r_ff_en;
  assign bus.ff_pre    = r_ff_pre;
  assign bus.ff_clr    = r_ff_clr;
  assign bus.done      = r_done;
  assign bus.q_model   = r_q_model;

`ifdef FFCTL_CNT_EN
  logic [7:0] r_cmd_count;

  // Count done pulses. The count updates on the same edge that raises done.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_cmd_count <= 8'd0;
    end else if (w_state_nxt == ST_DONE) begin
      r_cmd_count <= r_cmd_count + 8'd1;
    end
  end

  assign cmd_count = r_cmd_count;
`endif

endmodule

// File: doc/ffctl_seq.md
FFCTL_SEQ -- requirements
Module: ffctl_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of data path to downstream flop bank.
REQ-002 SHALL have parameter SETTLE, default 2: idle cycles after strobe before completion, legal 0..15.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accept.
REQ-007 SHALL have port cmd_op  input  2  00 LOAD, 01 PRESET, 10 CLEAR, 11 NOP.
REQ-008 SHALL have port cmd_data  input  WIDTH  load value, used only for LOAD.
REQ-009 SHALL have port ff_d  output  WIDTH  data to downstream flop bank.
REQ-010 SHALL have port ff_en  output  1  load-enable strobe, active-high.
REQ-011 SHALL have port ff_pre  output  1  preset strobe, active-high.
REQ-012 SHALL have port ff_clr  output  1  clear strobe, active-high.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port q_model  output  WIDTH  expected content of downstream bank.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, SETTLE, DONE; all outputs registered.
REQ-016 SHALL drive cmd_ready=1 only in IDLE; handshake occurs on cycle where cmd_valid and cmd_ready are both 1.
REQ-017 SHALL, on handshake, capture cmd_op and cmd_data and go to DONE if NOP, else DRIVE.
REQ-018 SHALL, in DRIVE, assert exactly one strobe for exactly one cycle: LOAD->ff_en, PRESET->ff_pre, CLEAR->ff_clr; strobes mutually exclusive at all times.
REQ-019 SHALL drive ff_d = captured data during a LOAD DRIVE cycle, and all-zeros otherwise.
REQ-020 SHALL update q_model at the end of the DRIVE cycle: LOAD->captured data, PRESET->all-ones, CLEAR->all-zeros; NOP leaves it unchanged.
REQ-021 SHALL leave DRIVE for SETTLE with a 4-bit counter loaded with SETTLE-1, or go directly to DONE when SETTLE=0.
REQ-022 SHALL decrement the counter each SETTLE cycle and go to DONE on the cycle the counter reads 0.
REQ-023 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-024 SHALL give these latencies from handshake at edge T: strobe high in cycle T+1, done high in cycle T+2+SETTLE; NOP gives done in cycle T+1.
REQ-025 SHALL ignore cmd_valid, cmd_op and cmd_data outside IDLE; a held cmd_valid is accepted on the first IDLE cycle after DONE.
REQ-026 SHALL give minimum command spacing of 3+SETTLE cycles for non-NOP and 2 cycles for NOP.

Reset
REQ-027 SHALL, on any rising edge with clr=0, enter IDLE, clear the counter, and drive ff_en=ff_pre=ff_clr=done=0, ff_d=0, q_model=0, cmd_ready=0.
REQ-028 SHALL assert cmd_ready=1 on the first edge with clr=1.
REQ-029 SHALL abandon any in-flight command when reset occurs mid-operation: no strobe and no done is issued for it afterwards.

Configuration
REQ-030 SHALL, when macro FFCTL_CNT_EN is defined, add output cmd_count (8 bits) that counts done pulses, wraps 255->0 and is reset to 0.
REQ-031 SHALL, when FFCTL_CNT_EN is undefined, omit the cmd_count port and its logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover LOAD: WIDTH=4, SETTLE=2, cmd_op=00, cmd_data=4'hA accepted at T -> ff_en=1 and ff_d=4'hA in T+1 only, q_model=4'hA from T+2, done in T+4.
REQ-033 SHALL cover PRESET then CLEAR back-to-back with cmd_valid held -> second handshake in the cycle after done, q_model 4'hF then 4'h0, ff_pre and ff_clr never high together.
REQ-034 SHALL cover NOP: cmd_op=11 at T -> no strobe, done in T+1, q_model unchanged.
REQ-035 SHALL cover SETTLE=0 LOAD 4'h5 -> strobe in T+1, done in T+2.
REQ-036 SHALL cover reset mid-operation: clr=0 during SETTLE -> all outputs 0 next edge, no done ever issued for that command, cmd_ready=1 on the first edge with clr=1.
REQ-037 SHALL cover, with FFCTL_CNT_EN defined, 257 NOP commands -> cmd_count=1.
